// File: rtl/pwm_frame_sequencer.sv
// Steps a table of (A, B) duty pairs one entry per PWM frame and drives the generator's limits,
// frame-load strobe and enable. Define PWM_SEQ_ONESHOT_EN to add a single-pass sequencing mode.
module pwm_frame_sequencer #(
  parameter int DEPTH = 8,
  parameter int AW    = 3,
  parameter int W     = 7,
  parameter int FW    = 8
) (
  input  logic          i_clkCore,
  input  logic          i_reset,
  input  logic          i_wr_en,
  input  logic [AW-1:0] i_wr_addr,
  input  logic [W-1:0]  i_wr_A,
  input  logic [W-1:0]  i_wr_B,
  input  logic [AW-1:0] i_seq_last,
  input  logic [FW-1:0] i_frame_len,
  input  logic          i_start,
  input  logic          i_stop,
`ifdef PWM_SEQ_ONESHOT_EN
  input  logic          i_oneshot,
`endif
  output logic [W-1:0]  o_A_val,
  output logic [W-1:0]  o_B_val,
  output logic          o_clkZ,
  output logic          o_en,
  output logic          o_busy,
  output logic [AW-1:0] o_idx,
  output logic          o_wrap
);

  typedef enum logic [1:0] {IDLE, PRIME, RUN, STOPPING} state_t;

  state_t          r_state;
  state_t          w_nextState;
  logic [2*W-1:0]  r_table [DEPTH];
  logic [W-1:0]    r_aVal;
  logic [W-1:0]    r_bVal;
  logic [AW-1:0]   r_idx;
  logic [FW-1:0]   r_cnt;
  logic            r_clkZ;
  logic            r_wrap;
  logic            r_wrapPend;
  logic            r_startReq;
  logic            r_oneshot;
  logic            w_oneshotIn;
  logic            w_fetch;
  logic            w_issueZ;
  logic            w_primeLoad;
  logic            w_lastEntry;
  logic [AW-1:0]   w_nextIdx;
  logic [FW-1:0]   w_len;

`ifdef PWM_SEQ_ONESHOT_EN
  assign w_oneshotIn = i_oneshot;
`else
  assign w_oneshotIn = 1'b0;
`endif

  // A zero frame length would stall the counter, so it is treated as one.
  assign w_len       = (i_frame_len == '0) ? FW'(1) : i_frame_len;
  assign w_lastEntry = (r_idx >= i_seq_last);
  assign w_nextIdx   = w_lastEntry ? '0 : r_idx + AW'(1);

  assign o_A_val = r_aVal;
  assign o_B_val = r_bVal;
  assign o_clkZ  = r_clkZ;
  assign o_idx   = r_idx;
  assign o_wrap  = r_wrap;
  assign o_en    = (r_state != IDLE);
  assign o_busy  = (r_state != IDLE);

  always_ff @(posedge i_clkCore or negedge i_reset) begin
    if (!i_reset) r_state <= IDLE;
    else          r_state <= w_nextState;
  end

  // Count 0 is the frame boundary (clkZ); count 1 is the fetch point one cycle earlier.
  always_comb begin
    w_nextState = r_state;
    w_fetch     = 1'b0;
    w_issueZ    = 1'b0;
    w_primeLoad = 1'b0;
    case (r_state)
      IDLE: begin
        if (r_startReq) begin
          w_nextState = PRIME;
          w_primeLoad = 1'b1;
        end
      end
      PRIME: begin
        w_issueZ    = 1'b1;
        w_nextState = i_stop ? STOPPING : RUN;
      end
      RUN: begin
        if (r_cnt == '0) begin
          w_issueZ = 1'b1;
          if (i_stop) w_nextState = STOPPING;
        end else if (r_cnt == FW'(1)) begin
          if (i_stop || (r_oneshot && w_lastEntry)) w_nextState = IDLE;
          else                                      w_fetch     = 1'b1;
        end else if (i_stop) begin
          w_nextState = STOPPING;
        end
      end
      STOPPING: begin
        if (r_cnt <= FW'(1)) w_nextState = IDLE;
      end
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge i_clkCore or negedge i_reset) begin
    if (!i_reset) begin
      for (int i = 0; i < DEPTH; i++) r_table[i] <= '0;
      r_aVal     <= '0;
      r_bVal     <= '0;
      r_idx      <= '0;
      r_cnt      <= '0;
      r_clkZ     <= 1'b0;
      r_wrap     <= 1'b0;
      r_wrapPend <= 1'b0;
      r_startReq <= 1'b0;
      r_oneshot  <= 1'b0;
    end else begin
      if (i_wr_en) r_table[i_wr_addr] <= {i_wr_A, i_wr_B};
      if (r_state == IDLE && !r_startReq) begin
        r_startReq <= i_start && !i_stop;
        r_oneshot  <= w_oneshotIn;
      end else begin
        r_startReq <= 1'b0;
      end
      r_clkZ <= w_issueZ;
      r_wrap <= w_issueZ && (r_state == RUN) && r_wrapPend;
      if (w_issueZ)          r_cnt <= w_len;
      else if (r_cnt != '0)  r_cnt <= r_cnt - FW'(1);
      if (w_primeLoad) begin
        {r_aVal, r_bVal} <= r_table[0];
        r_idx            <= '0;
        r_wrapPend       <= 1'b0;
      end else if (w_fetch) begin
        {r_aVal, r_bVal} <= r_table[w_nextIdx];
        r_idx            <= w_nextIdx;
        r_wrapPend       <= w_lastEntry;
      end
    end
  end

endmodule

// File: tb/tb_pwm_frame_sequencer.sv
// Self-checking bench for pwm_frame_sequencer: table-driven sequencing vectors with a clkZ scoreboard,
// plus hand-written sequences for stop, in-flight table writes, async reset and (optionally) oneshot.
`timescale 1ns/1ps
module tb_pwm_frame_sequencer;

  localparam int DEPTH = 8;
  localparam int AW    = 3;
  localparam int W     = 7;
  localparam int FW    = 8;

  typedef struct {
    int seqLast;
    int frameLen;
    int nFrames;
    int expPeriod;
    int expLastIdx;
  } vec_t;

  typedef struct {
    int cyc;
    int idx;
    int a;
    int b;
    int wrap;
  } zexp_t;

  logic          clkCore = 1'b0;
  logic          reset   = 1'b0;
  logic          wrEn    = 1'b0;
  logic [AW-1:0] wrAddr  = '0;
  logic [W-1:0]  wrA     = '0;
  logic [W-1:0]  wrB     = '0;
  logic [AW-1:0] seqLast = '0;
  logic [FW-1:0] frameLen = '0;
  logic          start   = 1'b0;
  logic          stop    = 1'b0;
  logic          oneshot = 1'b0;
  logic [W-1:0]  aVal;
  logic [W-1:0]  bVal;
  logic          clkZ;
  logic          en;
  logic          busy;
  logic [AW-1:0] idx;
  logic          wrap;

  int    vectors     = 0;
  int    miscompares = 0;
  int    cyc         = 0;
  int    prevA       = 0;
  int    prevB       = 0;
  int    shA [DEPTH];
  int    shB [DEPTH];
  zexp_t sbq [$];
  zexp_t monE;
  vec_t  vecs [5];
  vec_t  zeroVec;

  pwm_frame_sequencer dut (
    .i_clkCore   (clkCore),
    .i_reset     (reset),
    .i_wr_en     (wrEn),
    .i_wr_addr   (wrAddr),
    .i_wr_A      (wrA),
    .i_wr_B      (wrB),
    .i_seq_last  (seqLast),
    .i_frame_len (frameLen),
    .i_start     (start),
    .i_stop      (stop),
`ifdef PWM_SEQ_ONESHOT_EN
    .i_oneshot   (oneshot),
`endif
    .o_A_val     (aVal),
    .o_B_val     (bVal),
    .o_clkZ      (clkZ),
    .o_en        (en),
    .o_busy      (busy),
    .o_idx       (idx),
    .o_wrap      (wrap)
  );

  always #5 clkCore = ~clkCore;

  task automatic checkOutput(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Every clkZ pulse is matched against the oldest scoreboard entry.
  always @(posedge clkCore) begin
    cyc = cyc + 1;
    #1;
    if (clkZ) begin
      if (sbq.size() == 0) begin
        checkOutput("spuriousClkZ", int'(clkZ), 0);
      end else begin
        monE = sbq.pop_front();
        checkOutput("zCycle", cyc, monE.cyc);
        checkOutput("zIdx", int'(idx), monE.idx);
        checkOutput("zA", int'(aVal), monE.a);
        checkOutput("zB", int'(bVal), monE.b);
        checkOutput("zWrap", int'(wrap), monE.wrap);
        checkOutput("settleA", prevA, monE.a);
        checkOutput("settleB", prevB, monE.b);
      end
    end
    prevA = int'(aVal);
    prevB = int'(bVal);
  end

  task automatic waitUntil(input int c);
    while (cyc < c) @(negedge clkCore);
  endtask

  task automatic waitDrain(input int budget);
    int left;
    left = budget;
    while (sbq.size() != 0 && left > 0) begin
      @(negedge clkCore);
      left--;
    end
    checkOutput("drainPending", sbq.size(), 0);
    sbq.delete();
  endtask

  task automatic pushFrame(input int c, input int i, input int a, input int b, input int w);
    zexp_t e;
    e.cyc  = c;
    e.idx  = i;
    e.a    = a;
    e.b    = b;
    e.wrap = w;
    sbq.push_back(e);
  endtask

  task automatic writeEntry(input int addr, input int a, input int b);
    wrEn   = 1'b1;
    wrAddr = AW'(addr);
    wrA    = W'(a);
    wrB    = W'(b);
    @(negedge clkCore);
    wrEn = 1'b0;
    shA[addr] = a;
    shB[addr] = b;
  endtask

  task automatic checkIdleZero(input string tag);
    checkOutput({tag, "A"}, int'(aVal), 0);
    checkOutput({tag, "B"}, int'(bVal), 0);
    checkOutput({tag, "ClkZ"}, int'(clkZ), 0);
    checkOutput({tag, "En"}, int'(en), 0);
    checkOutput({tag, "Busy"}, int'(busy), 0);
    checkOutput({tag, "Idx"}, int'(idx), 0);
    checkOutput({tag, "Wrap"}, int'(wrap), 0);
  endtask

  // Start a sequence, expect nFrames clkZ pulses from the model, then stop and check the wind-down.
  task automatic applyStimulus(input vec_t v);
    int n;
    int eCyc;
    int k;
    int ei;
    seqLast  = AW'(v.seqLast);
    frameLen = FW'(v.frameLen);
    start    = 1'b1;
    n        = cyc + 1;
    for (k = 0; k < v.nFrames; k++) begin
      ei = k % (v.seqLast + 1);
      pushFrame(n + 2 + k * v.expPeriod, ei, shA[ei], shB[ei], (k > 0 && ei == 0) ? 1 : 0);
    end
    @(negedge clkCore);
    start = 1'b0;
    waitDrain(v.nFrames * v.expPeriod + 10);
    eCyc = n + 2 + (v.nFrames - 1) * v.expPeriod;
    stop = 1'b1;
    waitUntil(eCyc + v.expPeriod - 2);
    checkOutput("enBeforeEnd", int'(en), 1);
    waitUntil(eCyc + v.expPeriod - 1);
    checkOutput("enAtEnd", int'(en), 0);
    checkOutput("busyAtEnd", int'(busy), 0);
    checkOutput("idxHold", int'(idx), v.expLastIdx);
    checkOutput("aHold", int'(aVal), shA[v.expLastIdx]);
    checkOutput("bHold", int'(bVal), shB[v.expLastIdx]);
    stop = 1'b0;
    repeat (v.expPeriod + 3) @(negedge clkCore);
    checkOutput("idxAfterIdle", int'(idx), v.expLastIdx);
  endtask

  initial begin
    int n;
    for (int i = 0; i < DEPTH; i++) begin
      shA[i] = 0;
      shB[i] = 0;
    end
    vecs[0] = '{1, 9, 5, 10, 0};
    vecs[1] = '{1, 0, 4, 2, 1};
    vecs[2] = '{2, 3, 7, 4, 0};
    vecs[3] = '{0, 1, 3, 2, 0};
    vecs[4] = '{7, 2, 10, 3, 1};
    zeroVec = '{1, 4, 2, 5, 1};

    repeat (3) @(negedge clkCore);
    checkIdleZero("rstHeld");
    reset = 1'b1;
    @(negedge clkCore);

    start = 1'b1;
    stop  = 1'b1;
    repeat (4) @(negedge clkCore);
    checkOutput("startWithStopBusy", int'(busy), 0);
    start = 1'b0;
    stop  = 1'b0;
    @(negedge clkCore);

    applyStimulus(zeroVec);

    writeEntry(0, 10, 20);
    writeEntry(1, 30, 5);
    for (int i = 2; i < DEPTH; i++) writeEntry(i, (i * 17) % 128, 100 - i * 9);

    for (int v = 0; v < 5; v++) applyStimulus(vecs[v]);

    // Rewriting the presented entry must not disturb outputs until that entry is fetched again.
    seqLast  = AW'(1);
    frameLen = FW'(5);
    start    = 1'b1;
    n        = cyc + 1;
    pushFrame(n + 2, 0, 10, 20, 0);
    pushFrame(n + 8, 1, 30, 5, 0);
    pushFrame(n + 14, 0, 10, 20, 1);
    pushFrame(n + 20, 1, 50, 50, 0);
    @(negedge clkCore);
    start = 1'b0;
    waitUntil(n + 9);
    writeEntry(1, 50, 50);
    checkOutput("wrHoldA", int'(aVal), 30);
    checkOutput("wrHoldB", int'(bVal), 5);
    waitDrain(40);
    stop = 1'b1;
    waitUntil(n + 25);
    checkOutput("wrStopBusy", int'(busy), 0);
    checkOutput("wrStopA", int'(aVal), 50);
    stop = 1'b0;
    repeat (4) @(negedge clkCore);

    // Asynchronous reset in the middle of a running frame.
    seqLast  = AW'(1);
    frameLen = FW'(4);
    start    = 1'b1;
    n        = cyc + 1;
    pushFrame(n + 2, 0, 10, 20, 0);
    @(negedge clkCore);
    start = 1'b0;
    waitUntil(n + 4);
    checkOutput("preResetBusy", int'(busy), 1);
    #3 reset = 1'b0;
    #1 checkIdleZero("asyncRst");
    sbq.delete();
    repeat (2) @(negedge clkCore);
    reset = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      shA[i] = 0;
      shB[i] = 0;
    end
    @(negedge clkCore);
    applyStimulus(zeroVec);
    writeEntry(0, 10, 20);
    writeEntry(1, 30, 5);
    applyStimulus(vecs[0]);

`ifdef PWM_SEQ_ONESHOT_EN
    writeEntry(2, 7, 99);
    seqLast  = AW'(2);
    frameLen = FW'(2);
    oneshot  = 1'b1;
    start    = 1'b1;
    n        = cyc + 1;
    pushFrame(n + 2, 0, 10, 20, 0);
    pushFrame(n + 5, 1, 30, 5, 0);
    pushFrame(n + 8, 2, 7, 99, 0);
    @(negedge clkCore);
    start   = 1'b0;
    oneshot = 1'b0;
    waitDrain(30);
    waitUntil(n + 9);
    checkOutput("oneshotEnLast", int'(en), 1);
    waitUntil(n + 10);
    checkOutput("oneshotBusy", int'(busy), 0);
    checkOutput("oneshotIdx", int'(idx), 2);
    repeat (8) @(negedge clkCore);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
